// File: rtl/periph_bus_pkg.sv
// Shared definitions for the peripheral read path: FSM states,
// default region IDs and the data returned with error responses.
package periph_bus_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    // Region IDs as seen in the address decode field
    localparam logic [7:0] ID_DMEM = 8'h00;
    localparam logic [7:0] ID_VGA  = 8'h01;
    localparam logic [7:0] ID_SEG  = 8'h03;
    localparam logic [7:0] ID_BTN  = 8'h04;
    localparam logic [7:0] ID_SD   = 8'h08;

    // Channel 0 in the LSBs: DMEM, VGA, SEG, BTN, SD
    localparam logic [39:0] DEFAULT_CH_IDS = {ID_SD, ID_BTN, ID_SEG, ID_VGA, ID_DMEM};

    localparam logic [31:0] ERR_DEFAULT_DATA = 32'h0000_0000;

endpackage

// File: rtl/periph_addr_decode.sv
// Combinational region decoder: compares the address field against each
// channel's region ID; the lowest matching channel index wins.
module periph_addr_decode #(
    parameter int                  NUM_CH = 5,
    parameter int                  SW     = 4,
    parameter int                  IDX_W  = 3,
    parameter logic [NUM_CH*8-1:0] CH_IDS = '0
) (
    input  logic [SW-1:0]     i_field,
    output logic              o_hit,
    output logic [IDX_W-1:0]  o_idx,
    output logic [NUM_CH-1:0] o_onehot
);

    // Scan from the top so that a lower matching channel overrides a higher one
    always_comb begin
        o_hit    = 1'b0;
        o_idx    = '0;
        o_onehot = '0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (i_field == CH_IDS[i*8 +: SW]) begin
                o_hit       = 1'b1;
                o_idx       = IDX_W'(i);
                o_onehot    = '0;
                o_onehot[i] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/periph_read_bridge.sv
// Handshaked read bridge from the CPU load port to memory-mapped peripherals.
// Decodes the request, strobes the selected channel once, waits for its ack
// with a timeout and returns registered data plus an error flag.
module periph_read_bridge
    import periph_bus_pkg::*;
#(
    parameter int                  NUM_CH       = 5,
    parameter int                  DATA_W       = 32,
    parameter int                  ADDR_W       = 32,
    parameter int                  SEL_HI       = 31,
    parameter int                  SEL_LO       = 28,
    parameter logic [NUM_CH*8-1:0] CH_IDS       = DEFAULT_CH_IDS,
    parameter int                  TIMEOUT      = 15,
    parameter logic [DATA_W-1:0]   DEFAULT_DATA = ERR_DEFAULT_DATA
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     req_valid,
    input  logic [ADDR_W-1:0]        req_addr,
    output logic                     req_ready,
    output logic                     rsp_valid,
    input  logic                     rsp_ready,
    output logic [DATA_W-1:0]        rsp_data,
    output logic                     rsp_err,
    output logic [NUM_CH-1:0]        ch_sel,
    output logic                     ch_rd,
    output logic [ADDR_W-1:0]        ch_addr,
    input  logic [NUM_CH*DATA_W-1:0] ch_rdata,
    input  logic [NUM_CH-1:0]        ch_ack,
    output logic [15:0]              err_cnt,
    output logic [ADDR_W-1:0]        last_err_addr
);

    localparam int SW    = SEL_HI - SEL_LO + 1;
    localparam int IDX_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    state_t              r_state;
    logic [IDX_W-1:0]    r_idx;
    logic [7:0]          r_cnt;
    logic                r_rsp_valid;
    logic [DATA_W-1:0]   r_rsp_data;
    logic                r_rsp_err;
    logic [NUM_CH-1:0]   r_ch_sel;
    logic                r_ch_rd;
    logic [ADDR_W-1:0]   r_ch_addr;
    logic [15:0]         r_err_cnt;
    logic [ADDR_W-1:0]   r_last_err_addr;

    logic                w_hit;
    logic [IDX_W-1:0]    w_idx;
    logic [NUM_CH-1:0]   w_onehot;
    logic [DATA_W-1:0]   w_ch_data [NUM_CH];
    logic                w_ack;
    logic                w_timeout;

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    periph_addr_decode #(
        .NUM_CH (NUM_CH),
        .SW     (SW),
        .IDX_W  (IDX_W),
        .CH_IDS (CH_IDS)
    ) u_decode (
        .i_field  (req_addr[SEL_HI:SEL_LO]),
        .o_hit    (w_hit),
        .o_idx    (w_idx),
        .o_onehot (w_onehot)
    );

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch_data
        assign w_ch_data[g] = ch_rdata[g*DATA_W +: DATA_W];
    end

    // Only the latched channel's ack and data are ever looked at
    assign w_ack     = ch_ack[r_idx];
    assign w_timeout = (r_cnt == 8'(TIMEOUT - 1));
    assign req_ready = (r_state == IDLE);

    // Request/response FSM with all outputs registered
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state         <= IDLE;
            r_idx           <= '0;
            r_cnt           <= '0;
            r_rsp_valid     <= 1'b0;
            r_rsp_data      <= DEFAULT_DATA;
            r_rsp_err       <= 1'b0;
            r_ch_sel        <= '0;
            r_ch_rd         <= 1'b0;
            r_ch_addr       <= '0;
            r_err_cnt       <= '0;
            r_last_err_addr <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (req_valid) begin
                        r_ch_addr <= req_addr;
                        if (w_hit) begin
                            r_ch_sel <= w_onehot;
                            r_idx    <= w_idx;
                            r_ch_rd  <= 1'b1;
                            r_cnt    <= '0;
                            r_state  <= WAIT;
                        end else begin
                            r_rsp_data      <= DEFAULT_DATA;
                            r_rsp_err       <= 1'b1;
                            r_rsp_valid     <= 1'b1;
                            r_err_cnt       <= sat_inc(r_err_cnt);
                            r_last_err_addr <= req_addr;
                            r_state         <= RESP;
                        end
                    end
                end
                WAIT: begin
                    r_ch_rd <= 1'b0;
                    if (w_ack) begin
                        r_rsp_data  <= w_ch_data[r_idx];
                        r_rsp_err   <= 1'b0;
                        r_rsp_valid <= 1'b1;
                        r_ch_sel    <= '0;
                        r_state     <= RESP;
                    end else if (w_timeout) begin
                        r_rsp_data      <= DEFAULT_DATA;
                        r_rsp_err       <= 1'b1;
                        r_rsp_valid     <= 1'b1;
                        r_ch_sel        <= '0;
                        r_err_cnt       <= sat_inc(r_err_cnt);
                        r_last_err_addr <= r_ch_addr;
                        r_state         <= RESP;
                    end else begin
                        r_cnt <= r_cnt + 8'd1;
                    end
                end
                RESP: begin
                    // Return to the default value so no stale data lingers
                    if (rsp_ready) begin
                        r_rsp_valid <= 1'b0;
                        r_rsp_data  <= DEFAULT_DATA;
                        r_rsp_err   <= 1'b0;
                        r_state     <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign rsp_valid     = r_rsp_valid;
    assign rsp_data      = r_rsp_data;
    assign rsp_err       = r_rsp_err;
    assign ch_sel        = r_ch_sel;
    assign ch_rd         = r_ch_rd;
    assign ch_addr       = r_ch_addr;
    assign err_cnt       = r_err_cnt;
    assign last_err_addr = r_last_err_addr;

endmodule
